// File: rtl/noc_pkg.sv
// Shared definitions for the my_noc operand feeder: bus geometry helpers,
// feeder FSM encoding and the launch counter width.
package noc_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } feed_state_t;

  function automatic int lane_width(input int bit_width);
    return 2 * bit_width;
  endfunction

  function automatic int num_lanes(input int log_n_mul);
    return 1 << log_n_mul;
  endfunction

  function automatic int bus_width(input int bit_width, input int log_n_mul);
    return lane_width(bit_width) * num_lanes(log_n_mul);
  endfunction

endpackage

// File: rtl/noc_vec_fifo.sv
// W x DEPTH synchronous vector FIFO with flush; shared by the operand feeder
// and the result collector.
module noc_vec_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees room.
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/noc_operand_feeder.sv
// Buffers operand vectors and launches them onto the my_noc `in` bus as
// single-cycle pulses, gated by stall and spaced by a programmable drain gap.
module noc_operand_feeder
  import noc_pkg::*;
#(
  parameter int  bit_width  = 2,
  parameter int  log_n_mul  = 4,
  parameter int  fifo_depth = 4,
  parameter int  gap        = 32,
  localparam int NL         = num_lanes(log_n_mul),
  localparam int W          = bus_width(bit_width, log_n_mul)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [W-1:0]     i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [NL-1:0]    i_stall,
  output logic [W-1:0]     o_noc_in,
  output logic             o_launch,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_launch_cnt
);

  localparam int GW = $clog2(gap);

  feed_state_t              r_state;
  feed_state_t              w_state_next;
  logic [GW-1:0]            r_gap_cnt;
  logic [GW-1:0]            w_gap_next;
  logic [W-1:0]             r_noc_in;
  logic [W-1:0]             w_noc_next;
  logic                     r_launch;
  logic                     w_launch_next;
  logic [CNT_W-1:0]         r_launch_cnt;
  logic [CNT_W-1:0]         w_cnt_next;
  logic [W-1:0]             w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(fifo_depth):0] w_count;
  logic                     w_stall_free;
  logic                     w_fire;

  assign w_stall_free = (i_stall == '0);
  assign w_fire       = (r_state == ST_IDLE) && !w_empty && w_stall_free && !i_clear;

  noc_vec_fifo #(
    .W     (W),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_push  (i_s_valid),
    .i_data  (i_s_data),
    .i_pop   (w_fire),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_noc_in     <= '0;
      r_launch     <= 1'b0;
      r_launch_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_gap_cnt    <= w_gap_next;
      r_noc_in     <= w_noc_next;
      r_launch     <= w_launch_next;
      r_launch_cnt <= w_cnt_next;
    end
  end

  // Leaving GAP on the 1->0 step lets IDLE launch exactly gap edges after the last launch.
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    if (i_clear) begin
      w_state_next = ST_IDLE;
      w_gap_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            w_state_next = ST_GAP;
            w_gap_next   = GW'(gap - 1);
          end
        end
        ST_GAP: begin
          if (w_stall_free) begin
            w_gap_next = r_gap_cnt - 1'b1;
            if (r_gap_cnt == GW'(1)) w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_noc_next    = w_fire ? w_head : '0;
    w_launch_next = w_fire;
    w_cnt_next    = r_launch_cnt;
    if (i_clear)     w_cnt_next = '0;
    else if (w_fire) w_cnt_next = r_launch_cnt + 1'b1;
  end

  assign o_noc_in     = r_noc_in;
  assign o_launch     = r_launch;
  assign o_launch_cnt = r_launch_cnt;
  assign o_s_ready    = !w_full;
  assign o_busy       = (w_count != '0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_noc_operand_feeder.sv
// Self-checking bench for noc_operand_feeder: a queue-based launch model
// checked every cycle, plus directed literal checks on launch timing and data.
module tb_noc_operand_feeder;

  localparam int W     = 64;
  localparam int NL    = 16;
  localparam int DEPTH = 4;
  localparam int GAP   = 32;

  logic          i_clk     = 1'b0;
  logic          i_rst_n   = 1'b0;
  logic          i_clear   = 1'b0;
  logic [W-1:0]  i_s_data  = '0;
  logic          i_s_valid = 1'b0;
  logic [NL-1:0] i_stall   = '0;
  logic          o_s_ready;
  logic [W-1:0]  o_noc_in;
  logic          o_launch;
  logic          o_busy;
  logic [15:0]   o_launch_cnt;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  int          launchCycle[$];
  logic [W-1:0] launchData[$];

  noc_operand_feeder #(
    .bit_width  (2),
    .log_n_mul  (4),
    .fifo_depth (DEPTH),
    .gap        (GAP)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (i_clear),
    .i_s_data     (i_s_data),
    .i_s_valid    (i_s_valid),
    .o_s_ready    (o_s_ready),
    .i_stall      (i_stall),
    .o_noc_in     (o_noc_in),
    .o_launch     (o_launch),
    .o_busy       (o_busy),
    .o_launch_cnt (o_launch_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Model: a launch needs a queued vector, no stall, and at least gap-1
  // stall-free edges since the previous launch.
  logic [W-1:0] modelQ[$];
  logic [W-1:0] expNoc    = '0;
  logic         expLaunch = 1'b0;
  logic [15:0]  expCnt    = '0;
  int           modelFree = GAP - 1;
  bit           mFire;
  bit           mPush;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || i_clear) begin
      modelQ.delete();
      expNoc    = '0;
      expLaunch = 1'b0;
      expCnt    = '0;
      modelFree = GAP - 1;
    end else begin
      mFire = (modelQ.size() > 0) && (i_stall == '0) && (modelFree >= GAP - 1);
      mPush = i_s_valid && (modelQ.size() < DEPTH);
      if (mFire) begin
        expNoc    = modelQ.pop_front();
        expLaunch = 1'b1;
        expCnt    = expCnt + 16'd1;
        modelFree = 0;
      end else begin
        expNoc    = '0;
        expLaunch = 1'b0;
        if (i_stall == '0 && modelFree < GAP - 1) modelFree++;
      end
      if (mPush) modelQ.push_back(i_s_data);
    end
  end

  // Per-cycle comparison against the model, plus a log of observed launches.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      checkOutput("noc_in", o_noc_in, expNoc);
      checkOutput("launch", 64'(o_launch), 64'(expLaunch));
      checkOutput("launch_cnt", 64'(o_launch_cnt), 64'(expCnt));
      checkOutput("s_ready", 64'(o_s_ready), 64'(modelQ.size() < DEPTH));
      checkOutput("busy", 64'(o_busy), 64'((modelQ.size() > 0) || (modelFree < GAP - 1)));
      if (o_launch) begin
        launchCycle.push_back(cycle);
        launchData.push_back(o_noc_in);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic [NL-1:0] s, input logic c);
    i_s_data  = d;
    i_s_valid = v;
    i_stall   = s;
    i_clear   = c;
    @(negedge i_clk);
  endtask

  task automatic idleCycles(input int n, input logic [NL-1:0] s);
    repeat (n) applyStimulus('0, 1'b0, s, 1'b0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    int p;
    logic [W-1:0] t3Vec[5];

    repeat (3) @(negedge i_clk);
    checkOutput("rst_noc_in", o_noc_in, 64'h0);
    checkOutput("rst_launch", 64'(o_launch), 64'h0);
    checkOutput("rst_s_ready", 64'(o_s_ready), 64'h1);
    checkOutput("rst_busy", 64'(o_busy), 64'h0);
    checkOutput("rst_launch_cnt", 64'(o_launch_cnt), 64'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single vector: launches one edge after the push, for one cycle.
    b = launchCycle.size();
    applyStimulus(64'hFA0C123B65897E4D, 1'b1, '0, 1'b0);
    p = cycle;
    idleCycles(40, '0);
    checkOutput("t1_launch_count", 64'(launchCycle.size() - b), 64'd1);
    checkOutput("t1_latency", 64'(launchCycle[b] - p), 64'd1);
    checkOutput("t1_data", launchData[b], 64'hFA0C123B65897E4D);
    checkOutput("t1_cnt", 64'(o_launch_cnt), 64'd1);
    checkOutput("t1_busy", 64'(o_busy), 64'd0);

    // Back-to-back pushes launch exactly GAP cycles apart.
    applyStimulus('0, 1'b0, '0, 1'b1);
    checkOutput("t2_cnt_cleared", 64'(o_launch_cnt), 64'd0);
    b = launchCycle.size();
    applyStimulus(64'h0123456789ABCDEF, 1'b1, '0, 1'b0);
    checkOutput("t2_ready", 64'(o_s_ready), 64'd1);
    applyStimulus(64'hFEDCBA9876543210, 1'b1, '0, 1'b0);
    checkOutput("t2_ready2", 64'(o_s_ready), 64'd1);
    idleCycles(70, '0);
    checkOutput("t2_launch_count", 64'(launchCycle.size() - b), 64'd2);
    checkOutput("t2_spacing", 64'(launchCycle[b+1] - launchCycle[b]), 64'd32);
    checkOutput("t2_data0", launchData[b], 64'h0123456789ABCDEF);
    checkOutput("t2_data1", launchData[b+1], 64'hFEDCBA9876543210);
    checkOutput("t2_cnt", 64'(o_launch_cnt), 64'd2);

    // Fill under stall: 4 accepted, 5th refused; release drains in order.
    applyStimulus('0, 1'b0, '0, 1'b1);
    b = launchCycle.size();
    for (int i = 0; i < 5; i++) begin
      t3Vec[i] = 64'hC0DE000000000010 + 64'(i);
      applyStimulus(t3Vec[i], 1'b1, 16'h0001, 1'b0);
      if (i == 3) checkOutput("t3_ready_full", 64'(o_s_ready), 64'd0);
    end
    checkOutput("t3_no_launch", 64'(launchCycle.size() - b), 64'd0);
    checkOutput("t3_busy", 64'(o_busy), 64'd1);
    idleCycles(4 * 32 + 10, '0);
    checkOutput("t3_launch_count", 64'(launchCycle.size() - b), 64'd4);
    for (int k = 0; k < 4; k++) checkOutput("t3_data", launchData[b+k], t3Vec[k]);
    for (int k = 1; k < 4; k++) checkOutput("t3_spacing", 64'(launchCycle[b+k] - launchCycle[b+k-1]), 64'd32);
    checkOutput("t3_cnt", 64'(o_launch_cnt), 64'd4);

    // Five stalled cycles inside GAP stretch the spacing to 37.
    b = launchCycle.size();
    applyStimulus(64'h1357924680ACE135, 1'b1, '0, 1'b0);
    applyStimulus(64'h2468ACE013579BDF, 1'b1, '0, 1'b0);
    idleCycles(10, '0);
    idleCycles(5, 16'h8000);
    idleCycles(40, '0);
    checkOutput("t4_launch_count", 64'(launchCycle.size() - b), 64'd2);
    checkOutput("t4_spacing", 64'(launchCycle[b+1] - launchCycle[b]), 64'd37);
    checkOutput("t4_data1", launchData[b+1], 64'h2468ACE013579BDF);

    // Clear mid-GAP with three queued, then a fresh push launches at once.
    applyStimulus('0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(64'h5500000000000000 + 64'(i), 1'b1, '0, 1'b0);
    idleCycles(5, '0);
    applyStimulus('0, 1'b0, '0, 1'b1);
    checkOutput("t5_busy", 64'(o_busy), 64'd0);
    checkOutput("t5_cnt", 64'(o_launch_cnt), 64'd0);
    checkOutput("t5_noc_in", o_noc_in, 64'd0);
    checkOutput("t5_ready", 64'(o_s_ready), 64'd1);
    b = launchCycle.size();
    applyStimulus(64'h00C0FFEE12345678, 1'b1, '0, 1'b0);
    p = cycle;
    idleCycles(3, '0);
    checkOutput("t5_launch_count", 64'(launchCycle.size() - b), 64'd1);
    checkOutput("t5_latency", 64'(launchCycle[b] - p), 64'd1);
    checkOutput("t5_data", launchData[b], 64'h00C0FFEE12345678);

    // Async reset between edges mid-GAP, then a zero vector still launches.
    idleCycles(40, '0);
    applyStimulus(64'hDEADDEADDEADDEAD, 1'b1, '0, 1'b0);
    applyStimulus(64'hBEEFBEEFBEEFBEEF, 1'b1, '0, 1'b0);
    idleCycles(5, '0);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_noc_in", o_noc_in, 64'd0);
    checkOutput("t6_rst_launch", 64'(o_launch), 64'd0);
    checkOutput("t6_rst_busy", 64'(o_busy), 64'd0);
    checkOutput("t6_rst_cnt", 64'(o_launch_cnt), 64'd0);
    checkOutput("t6_rst_ready", 64'(o_s_ready), 64'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    b = launchCycle.size();
    applyStimulus(64'h0, 1'b1, '0, 1'b0);
    idleCycles(3, '0);
    checkOutput("t6_launch_count", 64'(launchCycle.size() - b), 64'd1);
    checkOutput("t6_data", launchData[b], 64'd0);
    checkOutput("t6_cnt", 64'(o_launch_cnt), 64'd1);
    idleCycles(40, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/noc_operand_feeder.md
Name: noc_operand_feeder

Overview:
- Transmit end of the my_noc operand input: buffers 16-lane operand vectors from an upstream producer and launches them onto the NoC `in` bus.
- Each launch is a single-cycle pulse, with zeros driven between launches.
- Launches are gated by the NoC `stall` vector and spaced by a programmable drain gap so the multiplier/adder tree never sees overlapping operand sets.
- Sits between the host/DMA operand source and my_noc, in the NoC's fastest clock domain (clk2 in the top-level clock bundle).

Parameters:
- bit_width, 2, operand half-width; lane width LW = 2*bit_width.
- log_n_mul, 4, log2 of lane count; NL = 2**log_n_mul; bus width W = LW*NL (64 by default).
- fifo_depth, 4, operand vectors buffered; power of two, >= 2.
- gap, 32, cycles from one launch to the next with no stall; minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of FIFO and FSM.
- s_data  in  W  operand vector from producer.
- s_valid  in  1  s_data valid.
- s_ready  out  1  feeder can accept.
- stall  in  NL  per-lane stall from my_noc.
- noc_in  out  W  drives my_noc `in`.
- launch  out  1  high in the cycle noc_in carries a vector.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- launch_cnt  out  16  launches since reset/clear, wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=0, asynchronous): noc_in=0, launch=0, FIFO empty, s_ready=1, busy=0, launch_cnt=0, FSM=IDLE.
- Release is synchronous to clk.
- FIFO:
  - Push when s_valid&&s_ready. s_ready = !full.
  - No bypass: a full FIFO deasserts s_ready even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, GAP.
- IDLE:
  - If FIFO non-empty and stall==0, then at the next edge noc_in<=head, launch<=1, pop, launch_cnt++, go to GAP with counter=gap-1.
  - Otherwise noc_in<=0, launch<=0.
- GAP:
  - noc_in<=0, launch<=0.
  - Counter decrements only in cycles where stall==0; it freezes while any stall bit is set.
  - When the counter reaches 0, go to IDLE.
- Latency: a vector pushed at edge t into an empty FIFO with FSM in IDLE and no stall appears on noc_in at edge t+1, for one cycle.
- Spacing: back-to-back queued vectors with stall held 0 launch exactly `gap` cycles apart (1 cycle data, gap-1 cycles zero). Each stalled cycle during GAP adds one cycle.
- Stall asserted in IDLE with data queued: no launch. Launch occurs at the first edge after stall returns to 0.
- A zero-valued vector is still a launch: launch=1, noc_in=0. launch is the authoritative marker.
- clear=1 (synchronous, has priority over push):
  - FIFO emptied, FSM to IDLE, noc_in=0, launch=0, launch_cnt=0.
  - A push in the same cycle is dropped; s_ready stays 1 that cycle only if the FIFO is not full.
- Reset mid-GAP or with data queued: everything returns to reset values immediately; queued vectors are lost.
- busy deasserts only when FIFO empty and FSM in IDLE.

Decomposition:
- Shared package noc_pkg: LW/NL/W derivation functions, FSM state encoding (IDLE=0, GAP=1), launch_cnt width constant (16).
- Sub-module noc_vec_fifo: parameterised W x fifo_depth synchronous FIFO with push, pop, clear, full, empty, count. Reused later by the result collector.

Test Plan:
- Reset, push 64'hFA0C123B65897E4D once, stall=0 -> noc_in=FA0C123B65897E4D for exactly 1 cycle one edge after push, launch=1 same cycle, then noc_in=0, launch_cnt=1, busy low after 32 cycles.
- Push 64'h0123456789ABCDEF and 64'hFEDCBA9876543210 back-to-back -> second launch exactly 32 cycles after first; s_ready stays 1; launch_cnt=2.
- Fill 5 vectors with fifo_depth=4, no launches allowed (stall=16'h0001 held) -> s_ready=0 after the 4th push, 5th not accepted. Release stall -> 4 launches at 32-cycle spacing in push order.
- stall=16'h8000 for 5 cycles mid-GAP -> next launch at 37 cycles instead of 32.
- clear asserted while 3 vectors queued and mid-GAP -> next cycle busy=0, launch_cnt=0, noc_in=0; a later push launches after 1 cycle with no residual gap.
- Async rst low mid-GAP between clock edges -> outputs reach reset values before the next edge; 0x0000 pushed after release -> launch=1 with noc_in=0.
